fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
- Sequences the shared 4-point FFT core (fft_4point_16bit).
- Accepts a serial stream of 16-bit samples over a valid/ready handshake and packs them into a 4-sample frame.
- Drives the core's parallel sample inputs and start level, then detects completion with a timeout.
- Captures the 4 frequency bins and streams them out serially over valid/ready. Sits between the sample source and the downstream bin consumer.

Parameters:
- DATA_W, 16, sample/bin width; must match the core.
- TIMEOUT_CYCLES, 32, maximum WAIT cycles before the frame is abandoned; must be ≥2.
- FRAME_CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample ready.
- s_data  in  DATA_W  input sample.
- core_sample0..core_sample3  out  DATA_W each  frame to core; sample k = k-th accepted.
- core_start  out  1  start level to core.
- core_freq0..core_freq3  in  DATA_W each  core results.
- core_done  in  1  core done level.
- m_valid  out  1  output bin valid.
- m_ready  in  1  output bin ready.
- m_data  out  DATA_W  output bin.
- m_index  out  2  bin number of m_data.
- m_last  out  1  high with bin 3.
- busy  out  1  high in any state other than COLLECT.
- err_timeout  out  1  sticky timeout flag.
- frame_cnt  out  FRAME_CNT_W  completed frames, wraps.

Behaviour:
- Reset (async, rst_n low): all outputs 0; state COLLECT; sample counter 0; armed 0. After release, s_ready=1 in COLLECT. Reset mid-frame discards all data, and core_start drops immediately.
- Transfer rule: a transfer occurs on a clk edge with valid&&ready.
- COLLECT:
  - s_ready=1.
  - Each input transfer writes s_data into slot cnt; cnt increments.
  - On the 4th transfer, go to START.
- START:
  - core_start=1; armed=0; timeout counter=0; next cycle go to WAIT.
  - Entry requires core_start low for ≥2 preceding cycles. If not yet satisfied, hold in COLLECT-full with core_start low until it is.
- WAIT:
  - core_start stays 1; timeout counter increments each cycle.
  - core_done low sets armed.
  - core_done high while armed: capture core_freq0..3 into the output buffer, drop core_start, go to DRAIN.
  - Counter reaching TIMEOUT_CYCLES with no completion: err_timeout=1 (cleared only by reset), core_start=0, frame dropped, go to COLLECT with cnt=0.
  - A stale high core_done from the previous frame never completes a frame, because armed is required.
- DRAIN:
  - m_valid=1; m_data = bin[idx]; m_index = idx; m_last = (idx==3).
  - Outputs hold stable while m_ready is low.
  - Each output transfer increments idx.
  - The transfer with idx==3: frame_cnt+1 (wraps at 2^FRAME_CNT_W), then go to COLLECT.
- Latency: 4th input transfer to first m_valid = 2 + core latency + 1 cycles.
- Output timing: s_ready and m_valid are registered and glitch-free. core_sample* are held constant from START until the next frame's START.
- Simultaneous events: completion and timeout in the same cycle count as completion.

Optional Feature:
- Macro: FFT_PINGPONG_EN.
- Defined:
  - A second 4-entry input buffer is added.
  - s_ready=1 whenever the fill buffer holds <4 samples, in every state, so collection overlaps START/WAIT/DRAIN.
  - When a drain finishes or a timeout occurs with the fill buffer full, the buffers swap and the block goes directly to START, still honouring the ≥2-cycle start-low gap.
  - A timeout drops only the in-flight frame.
- Undefined: single buffer only; s_ready=0 outside COLLECT.

Test Plan (bench uses a behavioural core model: done rises N cycles after start, freq_k = sample_k + 16'h0100, done held until start falls then re-cleared on next start):
- Basic: reset, send 16'h0001, 0002, 0003, 0004 with m_ready=1, N=6.
  - Bins out in order 0101, 0102, 0103, 0104; m_index 0..3; m_last only on the 4th; frame_cnt=1; err_timeout=0.
- Backpressure: same frame with m_ready low for 5 cycles at each bin → m_data/m_index stable throughout; exactly 4 transfers.
- Stale done: core_done held high from the previous frame, start a new frame → no capture until done falls and rises again.
- Timeout: model never raises done; send a frame.
  - After TIMEOUT_CYCLES=32 WAIT cycles: err_timeout=1, core_start=0, no m_valid, s_ready=1.
  - A next frame completes normally with err_timeout still 1.
- Reset mid-WAIT: rst_n low → core_start, m_valid, busy all 0 immediately. After release, a fresh frame 0005..0008 yields 0105..0108.
- FFT_PINGPONG_EN: stream 8 samples back-to-back with s_valid=1 → s_ready stays 1 for all 8; two frames output in order; start-low gap ≥2 cycles between frames; frame_cnt=2.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Frame sequencer for the shared 4-point FFT core. Packs four serial samples
// into a frame, starts the core, waits for completion (with a timeout) and
// streams the four bins back out serially.
//
// Build option: define FFT_PINGPONG_EN to let the fill buffer keep collecting
// the next frame while the current one is computed and drained. Without it the
// block accepts samples only while in COLLECT.
module fft_frame_sequencer #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int FRAME_CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // sample input stream
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  // FFT core interface
  output logic [DATA_W-1:0]      core_sample0,
  output logic [DATA_W-1:0]      core_sample1,
  output logic [DATA_W-1:0]      core_sample2,
  output logic [DATA_W-1:0]      core_sample3,
  output logic                   core_start,
  input  logic [DATA_W-1:0]      core_freq0,
  input  logic [DATA_W-1:0]      core_freq1,
  input  logic [DATA_W-1:0]      core_freq2,
  input  logic [DATA_W-1:0]      core_freq3,
  input  logic                   core_done,
  // bin output stream
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic [1:0]             m_index,
  output logic                   m_last,
  // status
  output logic                   busy,
  output logic                   err_timeout,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  localparam int          TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;        // samples held in the fill buffer
  logic [DATA_W-1:0]      fill_q [4];
  logic [DATA_W-1:0]      fill_d [4];
  logic [DATA_W-1:0]      smp_q  [4];          // frame presented to the core
  logic [DATA_W-1:0]      smp_d  [4];
  logic [DATA_W-1:0]      bin_q  [4];          // captured core results
  logic [DATA_W-1:0]      bin_d  [4];
  logic [1:0]             idx_q, idx_d;
  logic                   start_q, start_d;
  logic                   prev_low_q;          // core_start was low last cycle
  logic                   armed_q, armed_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   s_ready_q, s_ready_d;
  logic                   m_valid_q, m_valid_d;
  logic                   err_q, err_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

  logic s_xfer;
  logic m_xfer;
  logic full_next;
  logic gap_ok;
  logic launch;

  assign s_xfer = s_valid && s_ready_q;
  assign m_xfer = m_valid_q && m_ready;
  // START may only be entered after core_start has been low this cycle and the last.
  assign gap_ok = !start_q && prev_low_q;

  // Next-state logic for the sequencer and its datapath.
  // NOTE: every _d signal gets a default first so no path leaves it unassigned,
  // otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    smp_d     = smp_q;
    bin_d     = bin_q;
    idx_d     = idx_q;
    armed_d   = armed_q;
    tcnt_d    = tcnt_q;
    m_valid_d = m_valid_q;
    err_d     = err_q;
    fcnt_d    = fcnt_q;
    launch    = 1'b0;

    // NOTE: combinational logic uses blocking '=' so later statements see the
    // updated value (fill_d/cnt_d below); clocked blocks use '<=' only.
    if (s_xfer) begin
      fill_d[cnt_q[1:0]] = s_data;
      cnt_d              = cnt_q + 3'd1;
    end
    full_next = (cnt_d == 3'd4);

    case (state_q)
      ST_COLLECT: begin
        // Covers both the 4th transfer and a full buffer waiting on the start gap.
        if (full_next && gap_ok) launch = 1'b1;
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!core_done) armed_d = 1'b1;
        if (core_done && armed_q) begin
          // Completion wins over a simultaneous timeout.
          bin_d[0]  = core_freq0;
          bin_d[1]  = core_freq1;
          bin_d[2]  = core_freq2;
          bin_d[3]  = core_freq3;
          idx_d     = 2'd0;
          m_valid_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          // Drop the in-flight frame. core_start is high here, so a full fill
          // buffer is relaunched from COLLECT once the gap is met.
          err_d   = 1'b1;
          state_d = ST_COLLECT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (m_xfer) begin
          if (idx_q == 2'd3) begin
            m_valid_d = 1'b0;
            idx_d     = 2'd0;
            fcnt_d    = fcnt_q + FRAME_CNT_W'(1);
            state_d   = ST_COLLECT;
            if (full_next && gap_ok) launch = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    if (launch) begin
      state_d = ST_START;
      smp_d   = fill_d;
      cnt_d   = 3'd0;
      armed_d = 1'b0;
      tcnt_d  = '0;
    end

    start_d = (state_d == ST_START) || (state_d == ST_WAIT);
`ifdef FFT_PINGPONG_EN
    s_ready_d = (cnt_d < 3'd4);
`else
    s_ready_d = (state_d == ST_COLLECT) && (cnt_d < 3'd4);
`endif
  end

  // Control state, handshake flags and output-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_COLLECT;
      cnt_q      <= 3'd0;
      smp_q      <= '{default: '0};
      bin_q      <= '{default: '0};
      idx_q      <= 2'd0;
      start_q    <= 1'b0;
      prev_low_q <= 1'b0;
      armed_q    <= 1'b0;
      tcnt_q     <= '0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      smp_q      <= smp_d;
      bin_q      <= bin_d;
      idx_q      <= idx_d;
      start_q    <= start_d;
      prev_low_q <= !start_q;
      armed_q    <= armed_d;
      tcnt_q     <= tcnt_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      err_q      <= err_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Fill buffer storage.
  // NOTE: left unreset on purpose; a slot is always written before cnt lets it
  // be read, while smp_q/bin_q are reset because they drive ports directly.
  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  assign s_ready      = s_ready_q;
  assign core_sample0 = smp_q[0];
  assign core_sample1 = smp_q[1];
  assign core_sample2 = smp_q[2];
  assign core_sample3 = smp_q[3];
  assign core_start   = start_q;
  assign m_valid      = m_valid_q;
  assign m_data       = bin_q[idx_q];
  assign m_index      = idx_q;
  assign m_last       = m_valid_q && (idx_q == 2'd3);
  assign busy         = (state_q != ST_COLLECT);
  assign err_timeout  = err_q;
  assign frame_cnt    = fcnt_q;

endmodule
